// File: rtl/mat_frame_ctrl_pkg.sv
// Shared types and defaults for the matrix frame controller.
package mat_frame_ctrl_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int DIM_W_DEF   = 11;
  localparam int BLANK_W_DEF = 4;

  // Smallest frame that still produces a full 3x3 window.
  localparam int unsigned MIN_DIM = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic dims_ok(input int unsigned w, input int unsigned h);
    return (w >= MIN_DIM) && (h >= MIN_DIM);
  endfunction

endpackage

// File: rtl/mat_pos_cnt.sv
// Row/column position of the next pixel to accept, with end-of-row and end-of-frame flags.
module mat_pos_cnt
  import mat_frame_ctrl_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             step,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  output logic [DIM_W-1:0] col_idx,
  output logic [DIM_W-1:0] row_idx,
  output logic             row_last,
  output logic             frame_last
);

  assign row_last   = (col_idx == width - DIM_W'(1));
  assign frame_last = row_last && (row_idx == height - DIM_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_idx <= '0;
      row_idx <= '0;
    end else if (clr) begin
      col_idx <= '0;
      row_idx <= '0;
    end else if (step) begin
      if (row_last) begin
        col_idx <= '0;
        row_idx <= frame_last ? '0 : row_idx + DIM_W'(1);
      end else begin
        col_idx <= col_idx + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/mat_frame_ctrl.sv
// Frame controller feeding pixels to a 3x3 window generator with row blanking.
// Optional window statistics counter enabled by defining MAT_CTRL_STAT_EN.
module mat_frame_ctrl
  import mat_frame_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DIM_W   = DIM_W_DEF,
  parameter int BLANK_W = BLANK_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DIM_W-1:0]   cfg_width,
  input  logic [DIM_W-1:0]   cfg_height,
  input  logic [BLANK_W-1:0] cfg_hblank,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [DATA_W-1:0]  img,
  output logic               gray_out_en,
  input  logic               mat_en,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [DIM_W-1:0]   row_idx,
  output logic [DIM_W-1:0]   col_idx,
  output logic [2*DIM_W-1:0] win_cnt
);

  state_e             state_q, state_d;
  logic [DIM_W-1:0]   width_q, height_q;
  logic [BLANK_W-1:0] hblank_q, hb_cnt_q;
  logic               start_ok, start_bad, step, row_last, frame_last;

  assign s_ready = (state_q == ST_ACTIVE);
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

  // Abort beats both a start request and a coincident transfer.
  assign start_ok  = (state_q == ST_IDLE) && start && !abort &&
                     dims_ok(32'(cfg_width), 32'(cfg_height));
  assign start_bad = (state_q == ST_IDLE) && start && !abort &&
                     !dims_ok(32'(cfg_width), 32'(cfg_height));
  assign step      = s_valid && s_ready && !abort;

  mat_pos_cnt #(.DIM_W(DIM_W)) u_pos (
    .clk        (clk),
    .rst        (rst),
    .clr        (abort || start_ok),
    .step       (step),
    .width      (width_q),
    .height     (height_q),
    .col_idx    (col_idx),
    .row_idx    (row_idx),
    .row_last   (row_last),
    .frame_last (frame_last)
  );

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start_ok) state_d = ST_ACTIVE;
      ST_ACTIVE: if (step) begin
                   if (frame_last)                   state_d = ST_DONE;
                   else if (row_last && hblank_q != '0) state_d = ST_HBLANK;
                 end
      ST_HBLANK: if (hb_cnt_q == hblank_q - BLANK_W'(1)) state_d = ST_ACTIVE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      hblank_q    <= '0;
      hb_cnt_q    <= '0;
      cfg_err     <= 1'b0;
      img         <= '0;
      gray_out_en <= 1'b0;
    end else begin
      state_q     <= state_d;
      gray_out_en <= step;
      if (step) img <= s_data;
      hb_cnt_q <= (state_q == ST_HBLANK) ? hb_cnt_q + BLANK_W'(1) : '0;
      if (start_ok) begin
        width_q  <= cfg_width;
        height_q <= cfg_height;
        hblank_q <= cfg_hblank;
        cfg_err  <= 1'b0;
      end else if (start_bad) begin
        cfg_err  <= 1'b1;
      end
    end
  end

`ifdef MAT_CTRL_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      win_cnt <= '0;
    else if (start_ok)
      win_cnt <= '0;
    else if (mat_en && busy && win_cnt != '1)
      win_cnt <= win_cnt + (2*DIM_W)'(1);
  end
`else
  logic unused_mat_en;
  assign unused_mat_en = mat_en;
  assign win_cnt       = '0;
`endif

endmodule

// File: tb/tb_mat_frame_ctrl.sv
// Directed self-checking bench for mat_frame_ctrl.
module tb_mat_frame_ctrl;

  localparam int DATA_W  = 8;
  localparam int DIM_W   = 11;
  localparam int BLANK_W = 4;

`ifdef MAT_CTRL_STAT_EN
  localparam int EXP_WIN = 6;
`else
  localparam int EXP_WIN = 0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               start, abort, s_valid, mat_en;
  logic [DIM_W-1:0]   cfg_width, cfg_height;
  logic [BLANK_W-1:0] cfg_hblank;
  logic [DATA_W-1:0]  s_data;
  logic               s_ready, gray_out_en, busy, done, cfg_err;
  logic [DATA_W-1:0]  img;
  logic [DIM_W-1:0]   row_idx, col_idx;
  logic [2*DIM_W-1:0] win_cnt;

  always #5 clk = ~clk;

  mat_frame_ctrl #(.DATA_W(DATA_W), .DIM_W(DIM_W), .BLANK_W(BLANK_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cfg_width   (cfg_width),
    .cfg_height  (cfg_height),
    .cfg_hblank  (cfg_hblank),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .img         (img),
    .gray_out_en (gray_out_en),
    .mat_en      (mat_en),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .row_idx     (row_idx),
    .col_idx     (col_idx),
    .win_cnt     (win_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Results of the most recent run_frame call.
  int r_gray, r_img_bad, r_done_cnt, r_done_cyc, r_last_gray, r_stall, r_finished;
  int gray_cyc[$];

  task automatic run_frame(input int w, input int h, input int hb,
                           input bit toggle, input bit mid_start, input bit use_mat);
    int pix;
    bit xfer;
    r_gray = 0; r_img_bad = 0; r_done_cnt = 0; r_done_cyc = -1;
    r_last_gray = -1; r_stall = 0; r_finished = 0;
    gray_cyc.delete();
    cfg_width  = DIM_W'(w);
    cfg_height = DIM_W'(h);
    cfg_hblank = BLANK_W'(hb);
    start = 1'b1;
    tick();
    start = 1'b0;
    // Live config changes mid-frame must not affect the running frame.
    cfg_width  = 11'd1;
    cfg_height = 11'd1;
    cfg_hblank = 4'd9;
    check("frame_start_busy", 32'(busy), 32'd1);
    pix = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      s_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      s_data  = DATA_W'(pix);
      start   = mid_start && (cyc == 5);
      mat_en  = use_mat && (cyc >= 2) && (cyc < 8);
      xfer    = s_valid && s_ready;
      tick();
      start  = 1'b0;
      mat_en = 1'b0;
      if (xfer) pix++;
      if (gray_out_en) begin
        if (img !== DATA_W'(r_gray + 1)) r_img_bad++;
        r_gray++;
        r_last_gray = cyc;
        gray_cyc.push_back(cyc);
      end
      if (done) begin
        r_done_cnt++;
        r_done_cyc = cyc;
      end
      if (busy && !s_ready && !done) r_stall++;
      if (!busy) begin
        r_finished = 1;
        break;
      end
    end
    s_valid = 1'b0;
    check("frame_finished", r_finished, 32'd1);
  endtask

  typedef struct {
    logic [DIM_W-1:0] w;
    logic [DIM_W-1:0] h;
    logic             exp_err;
    logic             exp_busy;
  } cfg_vec_t;

  cfg_vec_t vecs[5];
  int       gray_after;

  initial begin
    vecs[0] = '{w: 11'd2, h: 11'd5, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[1] = '{w: 11'd3, h: 11'd3, exp_err: 1'b0, exp_busy: 1'b1};
    vecs[2] = '{w: 11'd5, h: 11'd2, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[3] = '{w: 11'd0, h: 11'd0, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[4] = '{w: 11'd4, h: 11'd3, exp_err: 1'b0, exp_busy: 1'b1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; mat_en = 1'b0;
    cfg_width = 11'd4; cfg_height = 11'd3; cfg_hblank = 4'd0; s_data = 8'd0;

    // Reset values, sampled before any clock edge.
    #2;
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_s_ready", 32'(s_ready),     32'd0);
    check("rst_gray",    32'(gray_out_en), 32'd0);
    check("rst_done",    32'(done),        32'd0);
    check("rst_cfg_err", 32'(cfg_err),     32'd0);
    check("rst_img",     32'(img),         32'd0);
    check("rst_row",     32'(row_idx),     32'd0);
    check("rst_col",     32'(col_idx),     32'd0);
    check("rst_win",     32'(win_cnt),     32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Configuration acceptance / rejection table.
    foreach (vecs[i]) begin
      cfg_width  = vecs[i].w;
      cfg_height = vecs[i].h;
      start = 1'b1;
      tick();
      start = 1'b0;
      check($sformatf("cfg%0d_err", i),     32'(cfg_err), 32'(vecs[i].exp_err));
      check($sformatf("cfg%0d_busy", i),    32'(busy),    32'(vecs[i].exp_busy));
      check($sformatf("cfg%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].exp_busy));
      tick();
      check($sformatf("cfg%0d_err_hold", i),  32'(cfg_err), 32'(vecs[i].exp_err));
      check($sformatf("cfg%0d_busy_hold", i), 32'(busy),    32'(vecs[i].exp_busy));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check($sformatf("cfg%0d_idle", i), 32'(busy), 32'd0);
    end

    // Start and abort together in IDLE: abort wins.
    cfg_width = 11'd4; cfg_height = 11'd3;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    tick();
    check("start_abort_busy2", 32'(busy), 32'd0);

    // 4x3, no blanking, continuous valid, 6 mat_en strobes.
    run_frame(4, 3, 0, 1'b0, 1'b0, 1'b1);
    check("a_gray_cnt",  r_gray,      32'd12);
    check("a_img_order", r_img_bad,   32'd0);
    check("a_last_gray", r_last_gray, 32'd11);
    check("a_done_cnt",  r_done_cnt,  32'd1);
    check("a_done_cyc",  r_done_cyc,  32'd11);
    check("a_stall",     r_stall,     32'd0);
    check("a_row",       32'(row_idx), 32'd0);
    check("a_col",       32'(col_idx), 32'd0);
    check("a_win_cnt",   32'(win_cnt), 32'(EXP_WIN));

    // 4x3 with two blank cycles between rows.
    run_frame(4, 3, 2, 1'b0, 1'b0, 1'b0);
    check("b_gray_cnt",  r_gray,     32'd12);
    check("b_img_order", r_img_bad,  32'd0);
    check("b_stall",     r_stall,    32'd4);
    check("b_done_cnt",  r_done_cnt, 32'd1);
    check("b_win_clr",   32'(win_cnt), 32'd0);
    if (gray_cyc.size() == 12) begin
      check("b_gap_4_5",  32'(gray_cyc[4] - gray_cyc[3]),  32'd3);
      check("b_gap_8_9",  32'(gray_cyc[8] - gray_cyc[7]),  32'd3);
      check("b_gap_1_2",  32'(gray_cyc[1] - gray_cyc[0]),  32'd1);
      check("b_span",     32'(gray_cyc[11] - gray_cyc[0]), 32'd15);
    end

    // 5x3 with s_valid toggling and a start pulse mid-frame.
    run_frame(5, 3, 0, 1'b1, 1'b1, 1'b0);
    check("c_gray_cnt",  r_gray,      32'd15);
    check("c_img_order", r_img_bad,   32'd0);
    check("c_last_gray", r_last_gray, 32'd28);
    check("c_done_cnt",  r_done_cnt,  32'd1);
    tick();
    tick();
    check("c_no_restart", 32'(busy), 32'd0);

    // Abort at row 1, col 2 with a coincident transfer.
    cfg_width = 11'd4; cfg_height = 11'd3; cfg_hblank = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (row_idx == 11'd1 && col_idx == 11'd2) break;
      s_data = DATA_W'(k + 1);
      tick();
    end
    check("abort_reach_row", 32'(row_idx), 32'd1);
    check("abort_reach_col", 32'(col_idx), 32'd2);
    abort = 1'b1;
    s_data = 8'hAA;
    tick();
    abort = 1'b0;
    s_valid = 1'b0;
    check("abort_busy", 32'(busy),        32'd0);
    check("abort_row",  32'(row_idx),     32'd0);
    check("abort_col",  32'(col_idx),     32'd0);
    check("abort_done", 32'(done),        32'd0);
    check("abort_gray", 32'(gray_out_en), 32'd0);
    tick();
    check("abort_done2", 32'(done), 32'd0);
    run_frame(4, 3, 0, 1'b0, 1'b0, 1'b0);
    check("post_abort_gray", r_gray,     32'd12);
    check("post_abort_img",  r_img_bad,  32'd0);
    check("post_abort_done", r_done_cnt, 32'd1);

    // Asynchronous reset in the middle of a frame.
    cfg_width = 11'd4; cfg_height = 11'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'd77;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_gray", 32'(gray_out_en), 32'd0);
    check("mid_rst_busy", 32'(busy),        32'd0);
    check("mid_rst_img",  32'(img),         32'd0);
    check("mid_rst_col",  32'(col_idx),     32'd0);
    rst = 1'b0;
    gray_after = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (gray_out_en) gray_after++;
    end
    s_valid = 1'b0;
    check("mid_rst_no_gray", gray_after, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
